// File: rtl/v_upd_arb.sv
`default_nettype none
// ============================================================================
// Module   : v_upd_arb  (plus package v_pkg with the shared v-core types)
// Purpose  : Shares the single list-update port of the v core between N_REQ
//            requesters. Each requester pushes into a private FIFO. A
//            round-robin scheduler pops one entry at a time and issues it to
//            the core. Issues are paced by the core's registered busy flag.
// Ports    : clk, rst               clock, synchronous active-high reset
//            i_req_vld/_prod_id/_cmd/_key/_size  per-requester push
//            o_req_rdy              per-requester FIFO not full
//            o_upd_*_r              registered update towards v
//            i_busy_r               v core busy (v.o_busy_r)
//            o_busy_r               arbiter has queued or in-flight work
//            o_grant_cnt_r, o_drop_cnt_r   only with V_UPD_ARB_STATS_EN
// Config   : `define V_UPD_ARB_STATS_EN adds saturating grant/drop counters.
// Revision : 1.0  initial release
// ============================================================================

package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;
endpackage

module v_upd_arb #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_req_vld,
  input  v_pkg::id_t   [N_REQ-1:0]    i_req_prod_id,
  input  v_pkg::cmd_t  [N_REQ-1:0]    i_req_cmd,
  input  v_pkg::key_t  [N_REQ-1:0]    i_req_key,
  input  v_pkg::size_t [N_REQ-1:0]    i_req_size,
  output logic [N_REQ-1:0]            o_req_rdy,
  output logic                        o_upd_vld_r,
  output v_pkg::id_t                  o_upd_prod_id_r,
  output v_pkg::cmd_t                 o_upd_cmd_r,
  output v_pkg::key_t                 o_upd_key_r,
  output v_pkg::size_t                o_upd_size_r,
  input  logic                        i_busy_r,
  output logic                        o_busy_r
`ifdef V_UPD_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0]      o_grant_cnt_r,
  output logic [15:0]                 o_drop_cnt_r
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;            // pointer carries a wrap bit
  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    v_pkg::id_t   id;
    v_pkg::cmd_t  cmd;
    v_pkg::key_t  key;
    v_pkg::size_t size;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     rr_q;
  logic [IW-1:0]     grant_q;
  logic              upd_vld_q;
  entry_t            upd_q;
  logic              busy_q;

  logic [N_REQ-1:0]  nonempty;
  logic [N_REQ-1:0]  nonempty_d;
  entry_t [N_REQ-1:0] head;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand;
  logic              any_req;
  logic              grant_fire;

  // --------------------------------------------------------------------------
  // Per-requester FIFOs
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fifo
    logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
    entry_t        mem_q [FIFO_DEPTH];
    logic          full, push, pop;

    assign full = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // Ready uses the pre-pop count, so a full FIFO refuses a push even when
    // it is popped in the same cycle.
    assign o_req_rdy[gi]  = !full && !rst;
    assign push           = i_req_vld[gi] && o_req_rdy[gi];
    assign pop            = grant_fire && (grant_idx == IW'(gi));
    assign wr_d           = wr_q + PW'(push);
    assign rd_d           = rd_q + PW'(pop);
    assign nonempty[gi]   = (wr_q != rd_q);
    assign nonempty_d[gi] = (wr_d != rd_d);
    assign head[gi]       = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= '{id:   i_req_prod_id[gi],
                                 cmd:  i_req_cmd[gi],
                                 key:  i_req_key[gi],
                                 size: i_req_size[gi]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pick: first non-empty requester at or after rr_q
  // --------------------------------------------------------------------------
  always_comb begin
    grant_idx = rr_q;
    any_req   = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % N_REQ);
      if (!any_req && nonempty[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // DRAIN with the core idle behaves exactly like IDLE, so a waiting entry is
  // granted in that same cycle; this gives the 3-cycle issue spacing
  // (ISSUE, GAP, grant) and issue one cycle after busy falls.
  assign grant_fire = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) &&
                      !i_busy_r && any_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_fire) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_GAP;
      // The core's busy flag is registered, so it cannot yet reflect the
      // update issued one cycle earlier; GAP waits it out unconditionally.
      ST_GAP:   state_d = ST_DRAIN;
      ST_DRAIN: if (!i_busy_r) state_d = grant_fire ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      upd_vld_q <= 1'b0;
      upd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      upd_vld_q <= grant_fire;
      busy_q    <= (state_d != ST_IDLE) || (|nonempty_d);
      if (grant_fire) begin
        upd_q   <= head[grant_idx];
        grant_q <= grant_idx;
      end
      if (state_q == ST_ISSUE) begin
        rr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign o_upd_vld_r     = upd_vld_q;
  assign o_upd_prod_id_r = upd_q.id;
  assign o_upd_cmd_r     = upd_q.cmd;
  assign o_upd_key_r     = upd_q.key;
  assign o_upd_size_r    = upd_q.size;
  assign o_busy_r        = busy_q;

`ifdef V_UPD_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics
  // --------------------------------------------------------------------------
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int k = 0; k < N_REQ; k++) begin
      drop_sum = drop_sum + 17'(i_req_vld[k] & ~o_req_rdy[k]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt_r = drop_cnt_q;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gcnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if ((state_q == ST_ISSUE) && (grant_q == IW'(gi)) &&
                   (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign o_grant_cnt_r[gi] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_v_upd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_upd_arb
// Purpose  : Self-checking bench for v_upd_arb. A queue-based reference model
//            predicts outputs every cycle; directed scenarios add literal
//            expectations for latency, ordering, back-pressure and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_v_upd_arb;

  localparam int N_REQ = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  cmd;
    logic [15:0] key;
    logic [7:0]  sz;
  } ent_t;

  typedef struct {
    int         c;
    logic [7:0] id;
  } iss_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [N_REQ-1:0]          req_vld;
  v_pkg::id_t   [N_REQ-1:0]  req_id;
  v_pkg::cmd_t  [N_REQ-1:0]  req_cmd;
  v_pkg::key_t  [N_REQ-1:0]  req_key;
  v_pkg::size_t [N_REQ-1:0]  req_size;
  logic [N_REQ-1:0]          req_rdy;
  logic                      upd_vld;
  v_pkg::id_t                upd_id;
  v_pkg::cmd_t               upd_cmd;
  v_pkg::key_t               upd_key;
  v_pkg::size_t              upd_size;
  logic                      busy_in;
  logic                      busy_out;
`ifdef V_UPD_ARB_STATS_EN
  logic [N_REQ-1:0][15:0]    grant_cnt;
  logic [15:0]               drop_cnt;
`endif

  v_upd_arb #(.N_REQ(N_REQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_vld       (req_vld),
    .i_req_prod_id   (req_id),
    .i_req_cmd       (req_cmd),
    .i_req_key       (req_key),
    .i_req_size      (req_size),
    .o_req_rdy       (req_rdy),
    .o_upd_vld_r     (upd_vld),
    .o_upd_prod_id_r (upd_id),
    .o_upd_cmd_r     (upd_cmd),
    .o_upd_key_r     (upd_key),
    .o_upd_size_r    (upd_size),
    .i_busy_r        (busy_in),
    .o_busy_r        (busy_out)
`ifdef V_UPD_ARB_STATS_EN
    ,
    .o_grant_cnt_r   (grant_cnt),
    .o_drop_cnt_r    (drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: per-requester queues, a round-robin pointer and the
  // number of cycles since the last issue (-1 when nothing is in flight).
  // An issue blocks grants for its own cycle and the following one; after
  // that a grant needs only the core to be idle.
  // --------------------------------------------------------------------------
  ent_t mq [N_REQ][$];
  int   since    = -1;
  int   rr       = 0;
  int   cyc      = 0;
  int   pre_sz [N_REQ];
  int   mg;
  bit   model_on = 1'b0;
  logic m_vld    = 1'b0;
  ent_t m_pay    = '0;
  logic m_busy   = 1'b0;
  int   m_drops  = 0;
  ent_t me;
  iss_t issue_log [$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) mq[i].delete();
      since    = -1;
      rr       = 0;
      m_vld    = 1'b0;
      m_pay    = '0;
      m_busy   = 1'b0;
      m_drops  = 0;
      model_on = 1'b1;
    end else begin
      mg = -1;
      for (int i = 0; i < N_REQ; i++) pre_sz[i] = mq[i].size();
      if (!busy_in && (since < 0 || since >= 2)) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (mg < 0 && pre_sz[(rr + k) % N_REQ] > 0) mg = (rr + k) % N_REQ;
        end
      end
      m_vld = (mg >= 0);
      if (mg >= 0) begin
        m_pay = mq[mg].pop_front();
        rr    = (mg + 1) % N_REQ;
        since = 0;
      end else if (since >= 0) begin
        if (since >= 2 && !busy_in) since = -1;
        else since++;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_vld[i]) begin
          if (pre_sz[i] < DEPTH) begin
            me.id = req_id[i]; me.cmd = req_cmd[i];
            me.key = req_key[i]; me.sz = req_size[i];
            mq[i].push_back(me);
          end else begin
            m_drops++;
          end
        end
      end
      m_busy = (since >= 0);
      for (int i = 0; i < N_REQ; i++) if (mq[i].size() > 0) m_busy = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model
  logic [N_REQ-1:0] exp_rdy;
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < N_REQ; i++) exp_rdy[i] = !rst && (mq[i].size() < DEPTH);
      chk("cyc_vld", 64'(upd_vld), 64'(m_vld));
      chk("cyc_payload", 64'({upd_id, upd_cmd, upd_key, upd_size}), 64'(m_pay));
      chk("cyc_busy", 64'(busy_out), 64'(m_busy));
      chk("cyc_rdy", 64'(req_rdy), 64'(exp_rdy));
      if (upd_vld === 1'b1) issue_log.push_back('{c: cyc, id: upd_id});
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int r, input ent_t e);
    req_vld[r]  = 1'b1;
    req_id[r]   = e.id;
    req_cmd[r]  = e.cmd;
    req_key[r]  = e.key;
    req_size[r] = e.sz;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
  endtask

  int t0;

  initial begin
    rst = 1'b1; busy_in = 1'b0; req_vld = '0;
    req_id = '0; req_cmd = '0; req_key = '0; req_size = '0;

    // Reset
    do_reset();
    chk("rst_vld", 64'(upd_vld), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'hF);

    // Single push on requester 1: issue two cycles later for exactly one cycle
    tick(1);
    set_req(1, '{id: 8'd3, cmd: 2'd1, key: 16'h0010, sz: 8'd5});
    tick(1);
    req_vld = '0;
    chk("single_lat1_vld", 64'(upd_vld), 64'd0);
    tick(1);
    chk("single_vld", 64'(upd_vld), 64'd1);
    chk("single_id", 64'(upd_id), 64'd3);
    chk("single_key", 64'(upd_key), 64'h10);
    chk("single_size", 64'(upd_size), 64'd5);
    tick(1);
    chk("single_pulse_len", 64'(upd_vld), 64'd0);
    tick(4);

    // All four requesters push together after a fresh reset
    do_reset();
    tick(1);
    issue_log.delete();
    t0 = cyc;
    for (int i = 0; i < N_REQ; i++)
      set_req(i, '{id: 8'(10 + i), cmd: 2'(i), key: 16'(16'h100 + i), sz: 8'(i + 1)});
    tick(1);
    req_vld = '0;
    tick(16);
    chk("rr_issue_count", 64'(issue_log.size()), 64'd4);
    if (issue_log.size() == 4) begin
      chk("rr_first_latency", 64'(issue_log[0].c - t0), 64'd2);
      for (int k = 0; k < 4; k++) chk("rr_order", 64'(issue_log[k].id), 64'(10 + k));
      for (int k = 1; k < 4; k++)
        chk("rr_spacing", 64'(issue_log[k].c - issue_log[k-1].c), 64'd3);
    end

    // Fill requester 0 while the core is busy; the fifth push is dropped
    issue_log.delete();
    busy_in = 1'b1;
    for (int p = 0; p < 5; p++) begin
      chk("full_rdy_before_push", 64'(req_rdy[0]), 64'(p < 4));
      set_req(0, '{id: 8'(20 + p), cmd: 2'd2, key: 16'(16'h200 + p), sz: 8'(p)});
      tick(1);
    end
    req_vld = '0;
    chk("full_rdy_after", 64'(req_rdy[0]), 64'd0);
    chk("full_no_issue", 64'(issue_log.size()), 64'd0);
`ifdef V_UPD_ARB_STATS_EN
    chk("stats_drop", 64'(drop_cnt), 64'd1);
    chk("stats_drop_model", 64'(drop_cnt), 64'(m_drops));
`endif
    busy_in = 1'b0;
    tick(16);
    chk("full_issue_count", 64'(issue_log.size()), 64'd4);
    if (issue_log.size() == 4)
      for (int k = 0; k < 4; k++) chk("full_order", 64'(issue_log[k].id), 64'(20 + k));
`ifdef V_UPD_ARB_STATS_EN
    chk("stats_grant0", 64'(grant_cnt[0]), 64'd5);
`endif

    // Core busy for 10 cycles after an issue
    set_req(1, '{id: 8'd30, cmd: 2'd0, key: 16'h0300, sz: 8'd1});
    tick(1);
    set_req(1, '{id: 8'd31, cmd: 2'd0, key: 16'h0301, sz: 8'd2});
    tick(1);
    req_vld = '0;
    chk("hold_first_vld", 64'(upd_vld), 64'd1);
    chk("hold_first_id", 64'(upd_id), 64'd30);
    busy_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("hold_blocked", 64'(upd_vld), 64'd0);
    end
    busy_in = 1'b0;
    tick(1);
    chk("hold_release_vld", 64'(upd_vld), 64'd1);
    chk("hold_release_id", 64'(upd_id), 64'd31);
    tick(4);

    // Reset while requester 2 holds three entries and the arbiter drains
    for (int p = 0; p < 4; p++) begin
      set_req(2, '{id: 8'(40 + p), cmd: 2'd3, key: 16'(16'h400 + p), sz: 8'(p)});
      if (p == 2) busy_in = 1'b1;
      tick(1);
    end
    req_vld = '0;
    chk("mid_busy_out", 64'(busy_out), 64'd1);
    chk("mid_rdy2", 64'(req_rdy[2]), 64'd1);
    do_reset();
    busy_in = 1'b0;
    issue_log.delete();
    chk("mid_rst_rdy", 64'(req_rdy), 64'hF);
    tick(10);
    chk("mid_rst_busy", 64'(busy_out), 64'd0);
    chk("mid_rst_no_issue", 64'(issue_log.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
